expr_recognizer: RTL and testbench
==================================

Name: expr_recognizer

Overview:
- Parametrised ASCII arithmetic-expression recognizer; consumes one character per accepted cycle.
- Successor to the single-digit "digit op digit" string checker. Adds:
  - multi-digit operands;
  - optional '-' and '/' operators;
  - parenthesis nesting;
  - input qualifier, synchronous clear, error classification and recovery on ';'.
- Sits after the UART/keyboard character stream, ahead of the calculator datapath.

Parameters:
- MAX_DIGITS, 4: max digits per operand. Must be 1..15.
- MAX_DEPTH, 3: max parenthesis nesting. Must be 1..15.
- ALLOW_SUB_DIV, 1: 1 = operator set {'+','*','-','/'}; 0 = {'+','*'} only.
- RECOVER, 1: 1 = ';' restarts recognition from any state; 0 = ';' is an illegal char and ERR is sticky until reset/sync_clr.
- DEPTH_W (localparam): $clog2(MAX_DEPTH+1).

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- sync_clr  in  1  synchronous clear; same effect as reset, applied at the clock edge.
- in_valid  in  1  in is consumed at the edge only when 1.
- in  in  8  ASCII character.
- out  out  1  1 = characters accepted so far form a complete valid expression.
- err  out  1  1 = recognizer is in ERR.
- err_code  out  2  first error cause: 0 SYNTAX, 1 LONG, 2 DEPTH, 3 UNBAL.
- depth  out  DEPTH_W  current open-parenthesis count.
- op_count  out  8  operators accepted since last restart; saturates at 255.

Behaviour:
- Reset (clr_n=0, async) and sync_clr=1 produce the same result:
  - state=OPND;
  - depth, digit counter, op_count = 0;
  - out=0, err=0, err_code=0.
- sync_clr=1 with in_valid=1: clear wins and the character is discarded.
- in_valid=0: all state and outputs hold.
- Character classes (decoded combinationally):
  - DIGIT = 48..57
  - OP = 43 '+', 42 '*', plus 45 '-' and 47 '/' when ALLOW_SUB_DIV=1
  - LP = 40 '('
  - RP = 41 ')'
  - SEMI = 59 ';'
  - anything else = ILLEGAL
- States:
  - OPND: expecting an operand (initial state, and after an operator or '(').
  - NUM: inside a number.
  - CLOSE: after ')'.
  - ERR.
- OPND:
  - DIGIT -> NUM, digcnt=1.
  - LP, if depth<MAX_DEPTH -> OPND, depth+1; otherwise -> ERR DEPTH.
  - RP, OP, ILLEGAL -> ERR SYNTAX.
- NUM:
  - DIGIT, if digcnt<MAX_DIGITS -> NUM, digcnt+1; otherwise -> ERR LONG.
  - OP -> OPND, op_count+1 (saturating).
  - RP, if depth>0 -> CLOSE, depth-1; if depth==0 -> ERR UNBAL.
  - LP, ILLEGAL -> ERR SYNTAX.
- CLOSE:
  - OP -> OPND, op_count+1.
  - RP: same rule as in NUM.
  - DIGIT, LP, ILLEGAL -> ERR SYNTAX.
- ERR:
  - Absorbs all characters.
  - err_code latched on entry and holds; the first error wins.
  - depth and op_count freeze at their values when ERR was entered.
- SEMI:
  - RECOVER=1: from any state -> OPND, with the same clearing as sync_clr.
  - RECOVER=0: treated as ILLEGAL.
- Output timing:
  - out, err, err_code are registered and computed from the next state.
  - 1-cycle latency: after the edge sampling char k, out reflects chars 1..k.
- Output definitions:
  - out = (state∈{NUM,CLOSE}) && depth==0 && !err.
  - err = (state==ERR).
- Counter widths:
  - digcnt is 4 bits; compare against MAX_DIGITS before incrementing, so it never wraps.
  - depth never exceeds MAX_DEPTH and never underflows.
- Async reset assertion mid-expression clears everything immediately, with no clock needed.

Decomposition:
- Shared header/package expr_defs:
  - ASCII constants (CH_0, CH_9, CH_PLUS, CH_STAR, CH_MINUS, CH_SLASH, CH_LP, CH_RP, CH_SEMI);
  - state encoding (OPND, NUM, CLOSE, ERR);
  - error codes (E_SYNTAX, E_LONG, E_DEPTH, E_UNBAL).
- One sub-module: expr_char_class.
  - Combinational; in[7:0] plus ALLOW_SUB_DIV -> one-hot class {digit, op, lp, rp, semi, illegal}.
  - Reused later by the calculator tokenizer.
- FSM, counters and output registers stay in expr_recognizer.

Test Plan:
- Defaults; feed "12+3" on consecutive cycles -> out after each char = 1,1,0,1; op_count=1; err=0.
- Feed "(4*(5-6))" -> out=0 through the 8th char (depth=1 after the first ')'), out=1 after the last ')', depth=0, op_count=2.
- MAX_DIGITS=4; "12345" -> after '5': err=1, err_code=1, out=0. Then "(" -> err_code stays 1.
- MAX_DEPTH=3; "((((" -> 4th '(' gives err_code=2, depth=3. Separately, "7)" -> err_code=3.
- RECOVER=1: "7)" then ';' then "9" -> err=0 and out=0 after ';', out=1 after '9'. With RECOVER=0 the same sequence keeps err=1, err_code=3.
- ALLOW_SUB_DIV=0: "3-4" -> err_code=0 at '-'.
- "3+" with an in_valid=0 gap -> outputs hold. clr_n pulsed low mid-stream -> out/err/depth/op_count = 0 before the next edge. sync_clr=1 together with in_valid=1 and '5' -> out=0 (char discarded).

Source files
------------

// File: rtl/expr_recognizer_pkg.sv
// Shared definitions for the expression recognizer and the character classifier:
// ASCII codes, recognizer state encoding and error-cause codes.
package expr_recognizer_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_LP    = 8'h28;
    localparam logic [7:0] CH_RP    = 8'h29;
    localparam logic [7:0] CH_SEMI  = 8'h3B;

    typedef enum logic [1:0] {
        OPND  = 2'd0,
        NUM   = 2'd1,
        CLOSE = 2'd2,
        ERR   = 2'd3
    } state_e;

    localparam logic [1:0] E_SYNTAX = 2'd0;
    localparam logic [1:0] E_LONG   = 2'd1;
    localparam logic [1:0] E_DEPTH  = 2'd2;
    localparam logic [1:0] E_UNBAL  = 2'd3;

endpackage

// File: rtl/expr_recognizer_char_class.sv
// Combinational ASCII classifier: exactly one of the six class outputs is high for any input.
module expr_recognizer_char_class
    import expr_recognizer_pkg::*;
#(
    parameter bit ALLOW_SUB_DIV = 1'b1
) (
    input  logic [7:0] i_ch,
    output logic       o_digit,
    output logic       o_op,
    output logic       o_lp,
    output logic       o_rp,
    output logic       o_semi,
    output logic       o_illegal
);

    logic w_sub_div;

    assign w_sub_div = ALLOW_SUB_DIV && (i_ch == CH_MINUS || i_ch == CH_SLASH);

    assign o_digit   = (i_ch >= CH_0) && (i_ch <= CH_9);
    assign o_op      = (i_ch == CH_PLUS) || (i_ch == CH_STAR) || w_sub_div;
    assign o_lp      = (i_ch == CH_LP);
    assign o_rp      = (i_ch == CH_RP);
    assign o_semi    = (i_ch == CH_SEMI);
    assign o_illegal = !(o_digit || o_op || o_lp || o_rp || o_semi);

endmodule

// File: rtl/expr_recognizer.sv
// Streaming recognizer for ASCII arithmetic expressions with multi-digit operands and
// parenthesis nesting; reports validity, first error cause, nesting depth and operator count.
module expr_recognizer
    import expr_recognizer_pkg::*;
#(
    parameter int unsigned MAX_DIGITS    = 4,
    parameter int unsigned MAX_DEPTH     = 3,
    parameter bit          ALLOW_SUB_DIV = 1'b1,
    parameter bit          RECOVER       = 1'b1,
    localparam int unsigned DEPTH_W      = $clog2(MAX_DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_clr_n,
    input  logic               i_sync_clr,
    input  logic               i_in_valid,
    input  logic [7:0]         i_in,
    output logic               o_out,
    output logic               o_err,
    output logic [1:0]         o_err_code,
    output logic [DEPTH_W-1:0] o_depth,
    output logic [7:0]         o_op_count
);

    localparam logic [3:0]         MAX_DIG_L   = 4'(MAX_DIGITS);
    localparam logic [DEPTH_W-1:0] MAX_DEPTH_L = DEPTH_W'(MAX_DEPTH);

    logic w_digit, w_op, w_lp, w_rp, w_semi, w_illegal;

    expr_recognizer_char_class #(
        .ALLOW_SUB_DIV (ALLOW_SUB_DIV)
    ) u_char_class (
        .i_ch      (i_in),
        .o_digit   (w_digit),
        .o_op      (w_op),
        .o_lp      (w_lp),
        .o_rp      (w_rp),
        .o_semi    (w_semi),
        .o_illegal (w_illegal)
    );

    state_e             r_state, w_state_d;
    logic [DEPTH_W-1:0] r_depth, w_depth_d;
    logic [3:0]         r_digcnt, w_digcnt_d;
    logic [7:0]         r_op_count, w_op_count_d;
    logic [1:0]         r_err_code, w_err_code_d;
    logic               r_out, r_err;
    logic               w_clear;

    // ';' restarts only when recovery is enabled; otherwise it falls through as illegal.
    assign w_clear = i_sync_clr || (i_in_valid && w_semi && RECOVER);

    always_comb begin
        w_state_d    = r_state;
        w_depth_d    = r_depth;
        w_digcnt_d   = r_digcnt;
        w_op_count_d = r_op_count;
        w_err_code_d = r_err_code;
        if (w_clear) begin
            w_state_d    = OPND;
            w_depth_d    = '0;
            w_digcnt_d   = '0;
            w_op_count_d = '0;
            w_err_code_d = E_SYNTAX;
        end else if (i_in_valid && r_state != ERR) begin
            if (w_illegal || w_semi) begin
                w_state_d    = ERR;
                w_err_code_d = E_SYNTAX;
            end else begin
                case (r_state)
                    OPND: begin
                        if (w_digit) begin
                            w_state_d  = NUM;
                            w_digcnt_d = 4'd1;
                        end else if (w_lp && r_depth < MAX_DEPTH_L) begin
                            w_depth_d = r_depth + 1'b1;
                        end else if (w_lp) begin
                            w_state_d    = ERR;
                            w_err_code_d = E_DEPTH;
                        end else begin
                            w_state_d    = ERR;
                            w_err_code_d = E_SYNTAX;
                        end
                    end
                    NUM, CLOSE: begin
                        if (w_digit && r_state == NUM && r_digcnt < MAX_DIG_L) begin
                            w_digcnt_d = r_digcnt + 4'd1;
                        end else if (w_digit && r_state == NUM) begin
                            w_state_d    = ERR;
                            w_err_code_d = E_LONG;
                        end else if (w_op) begin
                            w_state_d    = OPND;
                            w_op_count_d = (r_op_count == 8'hFF) ? r_op_count
                                                                 : r_op_count + 8'd1;
                        end else if (w_rp && r_depth != '0) begin
                            w_state_d = CLOSE;
                            w_depth_d = r_depth - 1'b1;
                        end else if (w_rp) begin
                            w_state_d    = ERR;
                            w_err_code_d = E_UNBAL;
                        end else begin
                            w_state_d    = ERR;
                            w_err_code_d = E_SYNTAX;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state    <= OPND;
            r_depth    <= '0;
            r_digcnt   <= '0;
            r_op_count <= '0;
            r_err_code <= E_SYNTAX;
            r_out      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_depth    <= w_depth_d;
            r_digcnt   <= w_digcnt_d;
            r_op_count <= w_op_count_d;
            r_err_code <= w_err_code_d;
            r_out      <= (w_state_d == NUM || w_state_d == CLOSE) && (w_depth_d == '0);
            r_err      <= (w_state_d == ERR);
        end
    end

    assign o_out      = r_out;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
    assign o_depth    = r_depth;
    assign o_op_count = r_op_count;

endmodule

// File: tb/tb_expr_recognizer.sv
// Bench for expr_recognizer: directed vector table, hand-written corner sequences and a
// random character stream checked against a string-rescanning reference model.
module tb_expr_recognizer;

    localparam int A_MD  = 4;
    localparam int A_DEP = 3;
    localparam int B_MD  = 2;
    localparam int B_DEP = 1;

    logic       clk = 1'b0;
    logic       clr_n, sync_clr, in_valid;
    logic [7:0] in_ch;

    logic       a_out, a_err;
    logic [1:0] a_code, a_depth;
    logic [7:0] a_ops;
    logic       b_out, b_err;
    logic [1:0] b_code;
    logic [0:0] b_depth;
    logic [7:0] b_ops;

    always #5 clk = ~clk;

    expr_recognizer #(
        .MAX_DIGITS    (A_MD),
        .MAX_DEPTH     (A_DEP),
        .ALLOW_SUB_DIV (1'b1),
        .RECOVER       (1'b1)
    ) u_dut_a (
        .i_clk      (clk),
        .i_clr_n    (clr_n),
        .i_sync_clr (sync_clr),
        .i_in_valid (in_valid),
        .i_in       (in_ch),
        .o_out      (a_out),
        .o_err      (a_err),
        .o_err_code (a_code),
        .o_depth    (a_depth),
        .o_op_count (a_ops)
    );

    expr_recognizer #(
        .MAX_DIGITS    (B_MD),
        .MAX_DEPTH     (B_DEP),
        .ALLOW_SUB_DIV (1'b0),
        .RECOVER       (1'b0)
    ) u_dut_b (
        .i_clk      (clk),
        .i_clr_n    (clr_n),
        .i_sync_clr (sync_clr),
        .i_in_valid (in_valid),
        .i_in       (in_ch),
        .o_out      (b_out),
        .o_err      (b_err),
        .o_err_code (b_code),
        .o_depth    (b_depth),
        .o_op_count (b_ops)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Characters accepted since the last restart, per instance.
    byte unsigned qa[$];
    byte unsigned qb[$];

    typedef struct {
        bit           sc;
        bit           v;
        byte unsigned ch;
        bit           e_out;
        bit           e_err;
        int           e_code;
        int           e_dep;
        int           e_ops;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic add(input bit sc, input bit v, input byte unsigned ch, input bit o,
                       input bit e, input int code, input int dep, input int ops);
        vec_t r;
        r.sc = sc; r.v = v; r.ch = ch;
        r.e_out = o; r.e_err = e; r.e_code = code; r.e_dep = dep; r.e_ops = ops;
        tbl.push_back(r);
    endtask

    function automatic bit is_op(input byte unsigned c, input bit asd);
        return c == 8'h2B || c == 8'h2A || (asd && (c == 8'h2D || c == 8'h2F));
    endfunction

    // Rescans the whole accepted string; legality of each char depends on the previous char.
    // prev kind: 0 none, 1 digit, 2 operator, 3 '(', 4 ')'.
    function automatic void model(input byte unsigned s[$], input int maxd, input int maxdep,
                                  input bit asd, output bit m_out, output bit m_err,
                                  output int m_code, output int m_dep, output int m_ops);
        int p, run, bad;
        byte unsigned c;
        p = 0; run = 0; m_dep = 0; m_ops = 0; m_err = 1'b0; m_code = 0;
        for (int i = 0; i < s.size(); i++) begin
            c = s[i];
            bad = -1;
            if (c >= 8'h30 && c <= 8'h39) begin
                if (p == 1) begin
                    if (run >= maxd) bad = 1;
                    else run++;
                end else if (p == 0 || p == 2 || p == 3) begin
                    run = 1;
                    p = 1;
                end else bad = 0;
            end else if (is_op(c, asd)) begin
                if (p == 1 || p == 4) begin
                    p = 2;
                    if (m_ops < 255) m_ops++;
                end else bad = 0;
            end else if (c == 8'h28) begin
                if (p == 0 || p == 2 || p == 3) begin
                    if (m_dep < maxdep) begin
                        m_dep++;
                        p = 3;
                    end else bad = 2;
                end else bad = 0;
            end else if (c == 8'h29) begin
                if (p == 1 || p == 4) begin
                    if (m_dep > 0) begin
                        m_dep--;
                        p = 4;
                    end else bad = 3;
                end else bad = 0;
            end else begin
                bad = 0;
            end
            if (bad >= 0) begin
                m_err = 1'b1;
                m_code = bad;
                break;
            end
        end
        m_out = !m_err && (p == 1 || p == 4) && m_dep == 0;
    endfunction

    // Drive one cycle away from the active edge and update the model strings.
    task automatic step(input bit sc, input bit v, input byte unsigned ch);
        @(negedge clk);
        sync_clr = sc; in_valid = v; in_ch = ch;
        @(posedge clk);
        #1;
        if (sc) begin
            qa.delete();
            qb.delete();
        end else if (v) begin
            if (ch == 8'h3B) qa.delete();   // instance A recovers on ';'
            else qa.push_back(ch);
            qb.push_back(ch);               // instance B treats ';' as illegal
        end
    endtask

    task automatic chk_model(input string tag, input bit do_a);
        bit mo, me;
        int mc, md, mops;
        if (do_a) begin
            model(qa, A_MD, A_DEP, 1'b1, mo, me, mc, md, mops);
            chk({tag, " a.out"}, a_out, mo);
            chk({tag, " a.err"}, a_err, me);
            chk({tag, " a.code"}, a_code, mc);
            chk({tag, " a.depth"}, a_depth, md);
            chk({tag, " a.ops"}, a_ops, mops);
        end
        model(qb, B_MD, B_DEP, 1'b0, mo, me, mc, md, mops);
        chk({tag, " b.out"}, b_out, mo);
        chk({tag, " b.err"}, b_err, me);
        chk({tag, " b.code"}, b_code, mc);
        chk({tag, " b.depth"}, b_depth, md);
        chk({tag, " b.ops"}, b_ops, mops);
    endtask

    function automatic byte unsigned rand_char();
        int r;
        byte unsigned ops[4];
        ops[0] = 8'h2B; ops[1] = 8'h2A; ops[2] = 8'h2D; ops[3] = 8'h2F;
        r = $urandom_range(0, 99);
        if (r < 45) return 8'(8'h30 + $urandom_range(0, 9));
        if (r < 62) return ops[$urandom_range(0, 3)];
        if (r < 73) return 8'h28;
        if (r < 84) return 8'h29;
        if (r < 88) return 8'h3B;
        if (r < 90) return 8'h61;
        return 8'(8'h30 + $urandom_range(0, 9));
    endfunction

    initial begin
        clr_n = 1'b0; sync_clr = 1'b0; in_valid = 1'b0; in_ch = 8'h00;
        #12;
        chk("reset a.out", a_out, 0);
        chk("reset a.err", a_err, 0);
        chk("reset a.code", a_code, 0);
        chk("reset a.depth", a_depth, 0);
        chk("reset a.ops", a_ops, 0);
        chk("reset b.err", b_err, 0);
        @(negedge clk);
        clr_n = 1'b1;

        // sc, v, ch, out, err, code, depth, ops (instance A)
        add(1, 1, "5", 0, 0, 0, 0, 0);
        add(0, 1, "1", 1, 0, 0, 0, 0);
        add(0, 1, "2", 1, 0, 0, 0, 0);
        add(0, 1, "+", 0, 0, 0, 0, 1);
        add(0, 1, "3", 1, 0, 0, 0, 1);
        add(1, 0, "0", 0, 0, 0, 0, 0);
        add(0, 1, "(", 0, 0, 0, 1, 0);
        add(0, 1, "4", 0, 0, 0, 1, 0);
        add(0, 1, "*", 0, 0, 0, 1, 1);
        add(0, 1, "(", 0, 0, 0, 2, 1);
        add(0, 1, "5", 0, 0, 0, 2, 1);
        add(0, 1, "-", 0, 0, 0, 2, 2);
        add(0, 1, "6", 0, 0, 0, 2, 2);
        add(0, 1, ")", 0, 0, 0, 1, 2);
        add(0, 1, ")", 1, 0, 0, 0, 2);
        add(1, 0, "0", 0, 0, 0, 0, 0);
        add(0, 1, "1", 1, 0, 0, 0, 0);
        add(0, 1, "2", 1, 0, 0, 0, 0);
        add(0, 1, "3", 1, 0, 0, 0, 0);
        add(0, 1, "4", 1, 0, 0, 0, 0);
        add(0, 1, "5", 0, 1, 1, 0, 0);
        add(0, 1, "(", 0, 1, 1, 0, 0);
        add(1, 1, "(", 0, 0, 0, 0, 0);
        add(0, 1, "(", 0, 0, 0, 1, 0);
        add(0, 1, "(", 0, 0, 0, 2, 0);
        add(0, 1, "(", 0, 0, 0, 3, 0);
        add(0, 1, "(", 0, 1, 2, 3, 0);
        add(1, 0, "0", 0, 0, 0, 0, 0);
        add(0, 1, "7", 1, 0, 0, 0, 0);
        add(0, 1, ")", 0, 1, 3, 0, 0);
        add(0, 1, ";", 0, 0, 0, 0, 0);
        add(0, 1, "9", 1, 0, 0, 0, 0);
        add(1, 0, "0", 0, 0, 0, 0, 0);
        add(0, 1, "3", 1, 0, 0, 0, 0);
        add(0, 1, "+", 0, 0, 0, 0, 1);
        add(0, 0, "7", 0, 0, 0, 0, 1);
        add(0, 0, ")", 0, 0, 0, 0, 1);
        add(0, 1, "4", 1, 0, 0, 0, 1);
        add(0, 1, "+", 0, 0, 0, 0, 2);
        add(0, 1, "(", 0, 0, 0, 1, 2);
        add(0, 1, "8", 0, 0, 0, 1, 2);
        add(0, 1, ")", 1, 0, 0, 0, 2);
        add(0, 1, ")", 0, 1, 3, 0, 2);
        add(0, 1, "+", 0, 1, 3, 0, 2);
        add(1, 0, "0", 0, 0, 0, 0, 0);
        add(0, 1, "1", 1, 0, 0, 0, 0);
        add(0, 1, "+", 0, 0, 0, 0, 1);
        add(0, 1, ")", 0, 1, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            step(tbl[i].sc, tbl[i].v, tbl[i].ch);
            tag = $sformatf("vec%0d", i);
            chk({tag, " out"}, a_out, tbl[i].e_out);
            chk({tag, " err"}, a_err, tbl[i].e_err);
            chk({tag, " code"}, a_code, tbl[i].e_code);
            chk({tag, " depth"}, a_depth, tbl[i].e_dep);
            chk({tag, " ops"}, a_ops, tbl[i].e_ops);
            chk_model(tag, 1'b0);
        end

        // Async reset mid-expression clears outputs without a clock edge.
        step(1, 0, "0");
        step(0, 1, "(");
        step(0, 1, "1");
        step(0, 1, "+");
        #1;
        clr_n = 1'b0;
        #1;
        chk("arst a.out", a_out, 0);
        chk("arst a.err", a_err, 0);
        chk("arst a.depth", a_depth, 0);
        chk("arst a.ops", a_ops, 0);
        chk("arst b.depth", b_depth, 0);
        chk("arst b.ops", b_ops, 0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        clr_n = 1'b1;

        // No recovery on ';' for instance B: error stays sticky.
        step(1, 0, "0");
        step(0, 1, "7");
        step(0, 1, ")");
        step(0, 1, ";");
        step(0, 1, "9");
        chk("norecover b.err", b_err, 1);
        chk("norecover b.code", b_code, 3);
        chk("recover a.err", a_err, 0);
        chk("recover a.out", a_out, 1);

        // '-' is illegal when subtraction/division are disabled.
        step(1, 0, "0");
        step(0, 1, "3");
        step(0, 1, "-");
        chk("nosub b.err", b_err, 1);
        chk("nosub b.code", b_code, 0);
        chk("sub a.err", a_err, 0);
        chk("sub a.ops", a_ops, 1);

        for (int i = 0; i < 2500; i++) begin
            bit sc, v;
            sc = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 9) != 0);
            step(sc, v, rand_char());
            chk_model($sformatf("rnd%0d", i), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
